hazard_stall_controller: RTL and testbench

- Sequences the 5-stage pipeline around hazards that forwarding cannot resolve.
- Detects load-use hazards, branch-in-ID operand hazards, multiply/divide HI/LO hazards and structural hazards.
- Drives PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush.
- Sits beside the forwarding unit in ID; owns the multi-cycle mult/div busy FSM and a stall-cycle performance counter.

---
 rtl/hazard_stall_controller.sv | 120 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard detector: stalls PC/IF-ID and bubbles ID/EX on unresolvable hazards, same cycle (combinational).
// Owns the mult/div busy FSM and a saturating stall-cycle counter; a stalled instruction simply holds in ID.
module hazard_stall_controller #(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [31:0]          ID_Instruction,
    input  logic                 ID_UsesRT,
    input  logic                 ID_IsBranch,
    input  logic                 ID_ReadsHiLo,
    input  logic                 ID_MulDivStart,
    input  logic                 BranchTaken,
    input  logic                 EX_RegWrite,
    input  logic                 EX_MemRead,
    input  logic [4:0]           EX_RegDest,
    input  logic                 MEM_MemRead,
    input  logic [4:0]           MEM_RegDest,
    input  logic                 StallCountClear,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 IDEXBubble,
    output logic                 IFIDFlush,
    output logic                 MulDivBusy,
    output logic                 State,
    output logic [CNT_WIDTH-1:0] StallCount
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [7:0]           MD_LOAD = 8'(MULDIV_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t     state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;

    logic [4:0] rs, rt;
    logic       unused_instr_bits;
    logic       ex_match, mem_match;
    logic       lu, ba, bl, hl, sh;
    logic       stall, issue, busy;

    assign rs = ID_Instruction[25:21];
    assign rt = ID_Instruction[20:16];
    assign unused_instr_bits = ^{ID_Instruction[31:26], ID_Instruction[15:0]};

    function automatic logic reg_match(input logic [4:0] d, input logic [4:0] s,
                                       input logic [4:0] t, input logic uses_t);
        return (d != 5'd0) && ((d == s) || (uses_t && (d == t)));
    endfunction

    assign ex_match  = reg_match(EX_RegDest, rs, rt, ID_UsesRT);
    assign mem_match = reg_match(MEM_RegDest, rs, rt, ID_UsesRT);
    assign busy      = (state_q == MD_BUSY);

    assign lu = EX_MemRead && ex_match;
    assign ba = ID_IsBranch && EX_RegWrite && !EX_MemRead && ex_match;
    assign bl = ID_IsBranch && ((EX_MemRead && ex_match) || (MEM_MemRead && mem_match));
    assign hl = ID_ReadsHiLo && busy;
    assign sh = ID_MulDivStart && busy;

    assign stall = lu | ba | bl | hl | sh;
    assign issue = ID_MulDivStart && !stall;

    // Reset forces the pipeline frozen with a bubble regardless of ID contents.
    assign PCWrite    = Reset && !stall;
    assign IFIDWrite  = Reset && !stall;
    assign IDEXBubble = !Reset || stall;
    assign IFIDFlush  = Reset && !stall && ID_IsBranch && BranchTaken;
    assign MulDivBusy = busy;
    assign State      = state_q;

    // The counter reaches 0 on the same edge that returns to RUN, so the
    // unit reports busy for MULDIV_LATENCY-1 cycles after the issue edge.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (issue) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q <= 8'd1) begin
                    state_d  = RUN;
                    md_cnt_d = 8'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= RUN;
            md_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
        end else if (StallCountClear) begin
            StallCount <= '0;
        end else if (stall && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MULDIV_LATENCY=4, CNT_WIDTH=2.
// ctl = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}: stall=0010, run=1100, run+flush=1101.
module tb_hazard_stall_controller;

    localparam int L  = 4;
    localparam int CW = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [31:0]   ID_Instruction;
    logic          ID_UsesRT, ID_IsBranch, ID_ReadsHiLo, ID_MulDivStart, BranchTaken;
    logic          EX_RegWrite, EX_MemRead;
    logic [4:0]    EX_RegDest;
    logic          MEM_MemRead;
    logic [4:0]    MEM_RegDest;
    logic          StallCountClear;
    logic          PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivBusy, State;
    logic [CW-1:0] StallCount;
    logic [3:0]    ctl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    assign ctl = {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush};

    hazard_stall_controller #(.MULDIV_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .Clock(Clock), .Reset(Reset), .ID_Instruction(ID_Instruction),
        .ID_UsesRT(ID_UsesRT), .ID_IsBranch(ID_IsBranch), .ID_ReadsHiLo(ID_ReadsHiLo),
        .ID_MulDivStart(ID_MulDivStart), .BranchTaken(BranchTaken),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
        .MEM_MemRead(MEM_MemRead), .MEM_RegDest(MEM_RegDest),
        .StallCountClear(StallCountClear), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush), .MulDivBusy(MulDivBusy),
        .State(State), .StallCount(StallCount)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] instr(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h23, rs, rt, 16'h1234};
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle;
        ID_Instruction = 32'd0; ID_UsesRT = 1'b0; ID_IsBranch = 1'b0;
        ID_ReadsHiLo = 1'b0; ID_MulDivStart = 1'b0; BranchTaken = 1'b0;
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_RegDest = 5'd0;
        MEM_MemRead = 1'b0; MEM_RegDest = 5'd0;
    endtask

    task automatic clear_cnt;
        idle();
        StallCountClear = 1'b1;
        tick();
        StallCountClear = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0; StallCountClear = 1'b0;
        idle();
        ID_IsBranch = 1'b1; BranchTaken = 1'b1; ID_MulDivStart = 1'b1;
        #2;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL reset_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (MulDivBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", MulDivBusy); else pass_cnt++;
        total_cnt++; if (State !== 1'b0) $display("FAIL reset_state: got %b want 0", State); else pass_cnt++;
        total_cnt++; if (StallCount !== 2'd0) $display("FAIL reset_count: got %0d want 0", StallCount); else pass_cnt++;
        idle();
        #3 Reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use;
        clear_cnt();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RegDest = 5'd5;
        ID_Instruction = instr(5'd5, 5'd2); ID_UsesRT = 1'b0;
        #2;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL lu_stall_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd1) $display("FAIL lu_count: got %0d want 1", StallCount); else pass_cnt++;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_RegDest = 5'd0;
        MEM_MemRead = 1'b1; MEM_RegDest = 5'd5;
        #2;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL lu_release_ctl: got %b want 1100", ctl); else pass_cnt++;
        MEM_MemRead = 1'b0; MEM_RegDest = 5'd0;
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RegDest = 5'd5;
        ID_Instruction = instr(5'd3, 5'd5); ID_UsesRT = 1'b0;
        #1;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL lu_rt_unused_ctl: got %b want 1100", ctl); else pass_cnt++;
        ID_UsesRT = 1'b1;
        #1;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL lu_rt_used_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd2) $display("FAIL lu_rt_count: got %0d want 2", StallCount); else pass_cnt++;
        idle();
    endtask

    task automatic test_alu_branch;
        clear_cnt();
        EX_RegWrite = 1'b1; EX_RegDest = 5'd4;
        ID_Instruction = instr(5'd4, 5'd0); ID_UsesRT = 1'b1; ID_IsBranch = 1'b1; BranchTaken = 1'b1;
        #2;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL ab_stall_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick();
        EX_RegWrite = 1'b0; EX_RegDest = 5'd0; MEM_RegDest = 5'd4;
        #2;
        total_cnt++; if (ctl !== 4'b1101) $display("FAIL ab_flush_ctl: got %b want 1101", ctl); else pass_cnt++;
        total_cnt++; if (StallCount !== 2'd1) $display("FAIL ab_count: got %0d want 1", StallCount); else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_load_branch;
        clear_cnt();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RegDest = 5'd7;
        ID_Instruction = instr(5'd3, 5'd7); ID_UsesRT = 1'b1; ID_IsBranch = 1'b1; BranchTaken = 1'b1;
        #2;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL lb_c1_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd1) $display("FAIL lb_c1_count: got %0d want 1", StallCount); else pass_cnt++;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_RegDest = 5'd0;
        MEM_MemRead = 1'b1; MEM_RegDest = 5'd7;
        #2;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL lb_c2_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd2) $display("FAIL lb_c2_count: got %0d want 2", StallCount); else pass_cnt++;
        MEM_MemRead = 1'b0; MEM_RegDest = 5'd0;
        #2;
        total_cnt++; if (ctl !== 4'b1101) $display("FAIL lb_c3_ctl: got %b want 1101", ctl); else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_muldiv;
        clear_cnt();
        ID_MulDivStart = 1'b1; ID_Instruction = instr(5'd8, 5'd9); ID_UsesRT = 1'b1;
        #2;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL md_issue_ctl: got %b want 1100", ctl); else pass_cnt++;
        tick();
        idle(); ID_ReadsHiLo = 1'b1;
        for (int i = 0; i < L - 1; i++) begin
            #2;
            total_cnt++; if (MulDivBusy !== 1'b1) $display("FAIL md_hl_busy[%0d]: got %b want 1", i, MulDivBusy); else pass_cnt++;
            total_cnt++; if (ctl !== 4'b0010) $display("FAIL md_hl_ctl[%0d]: got %b want 0010", i, ctl); else pass_cnt++;
            tick();
        end
        #2;
        total_cnt++; if (State !== 1'b0) $display("FAIL md_hl_state_run: got %b want 0", State); else pass_cnt++;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL md_mflo_go_ctl: got %b want 1100", ctl); else pass_cnt++;
        total_cnt++; if (StallCount !== 2'd3) $display("FAIL md_hl_count: got %0d want 3", StallCount); else pass_cnt++;
        tick();

        clear_cnt();
        ID_MulDivStart = 1'b1; ID_Instruction = instr(5'd8, 5'd9); ID_UsesRT = 1'b1;
        tick();
        for (int i = 0; i < L - 1; i++) begin
            #2;
            total_cnt++; if (State !== 1'b1) $display("FAIL md_sh_state[%0d]: got %b want 1", i, State); else pass_cnt++;
            total_cnt++; if (ctl !== 4'b0010) $display("FAIL md_sh_ctl[%0d]: got %b want 0010", i, ctl); else pass_cnt++;
            tick();
        end
        #2;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL md_div_go_ctl: got %b want 1100", ctl); else pass_cnt++;
        tick();
        idle();
        total_cnt++; if (MulDivBusy !== 1'b1) $display("FAIL md_div_busy: got %b want 1", MulDivBusy); else pass_cnt++;
        total_cnt++; if (StallCount !== 2'd3) $display("FAIL md_sh_count: got %0d want 3", StallCount); else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++; if (State !== 1'b0) $display("FAIL md_div_done_state: got %b want 0", State); else pass_cnt++;
    endtask

    task automatic test_zero_dest;
        clear_cnt();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RegDest = 5'd0;
        MEM_MemRead = 1'b1; MEM_RegDest = 5'd0;
        ID_Instruction = instr(5'd0, 5'd0); ID_UsesRT = 1'b1; ID_IsBranch = 1'b1;
        #2;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL zero_dest_ctl: got %b want 1100", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd0) $display("FAIL zero_dest_count: got %0d want 0", StallCount); else pass_cnt++;
        idle();
    endtask

    task automatic test_saturation;
        logic [CW-1:0] exp_c;
        clear_cnt();
        EX_MemRead = 1'b1; EX_RegDest = 5'd5; ID_Instruction = instr(5'd5, 5'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_c = (i + 1 > 3) ? CW'(3) : CW'(i + 1);
            total_cnt++; if (StallCount !== exp_c) $display("FAIL sat_count[%0d]: got %0d want %0d", i, StallCount, exp_c); else pass_cnt++;
        end
        StallCountClear = 1'b1;
        #2;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL sat_clear_stall_ctl: got %b want 0010", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd0) $display("FAIL sat_clear_count: got %0d want 0", StallCount); else pass_cnt++;
        StallCountClear = 1'b0;
        idle();
    endtask

    task automatic test_reset_mid_busy;
        clear_cnt();
        ID_MulDivStart = 1'b1; ID_Instruction = instr(5'd8, 5'd9);
        tick();
        idle(); ID_ReadsHiLo = 1'b1;
        tick();
        #2;
        total_cnt++; if (State !== 1'b1) $display("FAIL rmb_pre_state: got %b want 1", State); else pass_cnt++;
        total_cnt++; if (StallCount !== 2'd1) $display("FAIL rmb_pre_count: got %0d want 1", StallCount); else pass_cnt++;
        Reset = 1'b0;
        #1;
        total_cnt++; if (State !== 1'b0) $display("FAIL rmb_state: got %b want 0", State); else pass_cnt++;
        total_cnt++; if (MulDivBusy !== 1'b0) $display("FAIL rmb_busy: got %b want 0", MulDivBusy); else pass_cnt++;
        total_cnt++; if (StallCount !== 2'd0) $display("FAIL rmb_count: got %0d want 0", StallCount); else pass_cnt++;
        total_cnt++; if (ctl !== 4'b0010) $display("FAIL rmb_ctl: got %b want 0010", ctl); else pass_cnt++;
        #1 Reset = 1'b1;
        tick();
        #2;
        total_cnt++; if (ctl !== 4'b1100) $display("FAIL rmb_mflo_ctl: got %b want 1100", ctl); else pass_cnt++;
        tick();
        total_cnt++; if (StallCount !== 2'd0) $display("FAIL rmb_post_count: got %0d want 0", StallCount); else pass_cnt++;
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_branch();
        test_load_branch();
        test_muldiv();
        test_zero_dest();
        test_saturation();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
